apb_slave_mem: RTL and testbench
================================

APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, PADDR width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, PWDATA/PRDATA width in bits.
REQ-003 SHALL have parameter DEPTH, default 64, number of word locations; PADDR is a word index.
REQ-004 SHALL have parameter WAIT_CYCLES, default 0, range 0-7; PREADY-low ACCESS cycles inserted per transfer.
REQ-005 SHALL have port PCLK  input  1  APB clock; the only clock; all state changes on its rising edge.
REQ-006 SHALL have port PRESETn  input  1  reset; asynchronous assert, active-low.
REQ-007 SHALL have port PSEL  input  1  slave select.
REQ-008 SHALL have port PENABLE  input  1  access-phase indicator.
REQ-009 SHALL have port PWRITE  input  1  1 = write, 0 = read.
REQ-010 SHALL have port PADDR  input  ADDR_WIDTH  word address.
REQ-011 SHALL have port PWDATA  input  DATA_WIDTH  write data.
REQ-012 SHALL have port PRDATA  output  DATA_WIDTH  read data, registered.
REQ-013 SHALL have port PREADY  output  1  transfer completion, registered.
REQ-014 SHALL have port PSLVERR  output  1  error response, valid only while PREADY=1.
REQ-015 SHALL have port err_cnt  output  8  count of error-terminated transfers, saturating at 255.

Function
REQ-016 SHALL implement FSM states IDLE, SETUP, WAIT, READY.
REQ-017 IDLE -> SETUP when PSEL=1 and PENABLE=0; otherwise stays IDLE.
REQ-018 SETUP -> READY when WAIT_CYCLES=0, else SETUP -> WAIT with wait counter loaded to WAIT_CYCLES-1.
REQ-019 WAIT decrements the counter each cycle; WAIT -> READY on the cycle the counter is 0.
REQ-020 PREADY SHALL be 1 only in READY; a transfer completes on the edge ending READY with PSEL=PENABLE=1.
REQ-021 READY -> SETUP when PSEL=1 and PENABLE=0 on the next cycle (back-to-back); otherwise READY -> IDLE.
REQ-022 Latency SHALL be exactly WAIT_CYCLES+1 ACCESS cycles: PREADY high in the (WAIT_CYCLES+1)th cycle with PENABLE=1.
REQ-023 PADDR, PWRITE and PWDATA SHALL be captured in SETUP; later changes during WAIT/READY are ignored.
REQ-024 Address violation: captured PADDR >= DEPTH.
REQ-025 On violation: PSLVERR=1 in READY, write suppressed (memory unchanged), PRDATA=0.
REQ-026 Valid write: mem[PADDR] <= PWDATA on the edge ending READY; PSLVERR=0.
REQ-027 Valid read: PRDATA = mem[PADDR], presented in READY, held until the next READY; PSLVERR=0.
REQ-028 Protocol violation: PSEL=0 or PENABLE=0 during WAIT/READY aborts the transfer -> IDLE, no memory write, err_cnt +1, PREADY stays 0.
REQ-029 PENABLE=1 while in IDLE (no setup phase) SHALL be ignored, with no state change and no response.
REQ-030 err_cnt SHALL increment by 1 per address violation completion and per abort, and hold at 255.
REQ-031 PSLVERR SHALL be 0 in every state other than READY.
REQ-032 Read-after-write to the same address in the next transfer SHALL return the new data.

Reset
REQ-033 PRESETn=0 SHALL asynchronously force state IDLE, PREADY=0, PSLVERR=0, PRDATA=0, err_cnt=0, wait counter=0, all memory words=0.
REQ-034 Reset mid-transfer SHALL discard the transfer; no memory write occurs on the reset edge.
REQ-035 After PRESETn deasserts, the first SETUP SHALL be recognised on the first rising PCLK edge.

Verification
REQ-036 WAIT_CYCLES=0: write 0xDEADBEEF to addr 5, then read addr 5 -> PREADY high in the first ACCESS cycle; PRDATA=0xDEADBEEF; PSLVERR=0.
REQ-037 DEPTH=64: write 0x12345678 to addr 64, then read addr 64 -> PSLVERR=1 both times; PRDATA=0; err_cnt=2; a read of addr 0 returns 0.
REQ-038 WAIT_CYCLES=3: read addr 10 -> exactly 3 PENABLE cycles with PREADY=0, then 1 cycle with PREADY=1.
REQ-039 Back-to-back writes to addrs 1 and 2 with no IDLE between them -> both committed; reads return the written values.
REQ-040 WAIT_CYCLES=2: drop PSEL during WAIT -> FSM returns to IDLE, target word unchanged, err_cnt=1.
REQ-041 Assert PRESETn=0 in the WAIT state of a write to addr 3 -> PREADY=0 immediately; mem[3] reads 0 after reset.

Source files
------------

// File: rtl/apb_slave_mem.sv
`timescale 1ns/1ps
// APB word-addressed memory slave with parameterised wait states and error counting.
// Latency: PREADY rises in access cycle WAIT_CYCLES+1. PREADY, PSLVERR and PRDATA are registered.
// Backpressure: the slave stalls the master by holding PREADY low for WAIT_CYCLES access cycles.
// Ports: PCLK/PRESETn are the clock and async active-low reset.
//        PSEL/PENABLE/PWRITE/PADDR/PWDATA form the APB request.
//        PRDATA/PREADY/PSLVERR form the response.
//        err_cnt counts error-terminated and aborted transfers, saturating at 255.
module apb_slave_mem #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic [7:0]            err_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] READY = 2'd3;

  localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] WAIT_LOAD = 3'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  // One extra bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
  typedef logic [ADDR_WIDTH:0] aext_t;

  logic [1:0]            state_q, state_eff, state_d;
  logic [2:0]            wcnt_q, wcnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_cur;
  logic                  write_q, write_cur;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  access, abort, commit;
  logic                  cur_bad, q_bad;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign access = PSEL && PENABLE;

  // The APB setup cycle is the SETUP state. It is seen combinationally from IDLE,
  // so the registered state moves straight to WAIT/READY on the edge that ends it.
  // That keeps the latency at WAIT_CYCLES+1 access cycles.
  always_comb begin
    state_eff = state_q;
    if (state_q == IDLE && PSEL && !PENABLE) begin
      state_eff = SETUP;
    end
    state_d = state_eff;
    wcnt_d  = wcnt_q;
    abort   = 1'b0;
    commit  = 1'b0;
    case (state_eff)
      IDLE: state_d = IDLE;
      SETUP: begin
        if (WAIT_CYCLES == 0) begin
          state_d = READY;
        end else begin
          state_d = WAIT;
          wcnt_d  = WAIT_LOAD;
        end
      end
      WAIT: begin
        if (!access) begin
          abort   = 1'b1;
          state_d = IDLE;
          wcnt_d  = 3'd0;
        end else if (wcnt_q == 3'd0) begin
          state_d = READY;
        end else begin
          wcnt_d = wcnt_q - 3'd1;
        end
      end
      default: begin
        // READY always falls back to IDLE.
        // A back-to-back setup is picked up from IDLE on the following cycle.
        state_d = IDLE;
        if (access) begin
          commit = 1'b1;
        end else begin
          abort = 1'b1;
        end
      end
    endcase
  end

  // Transfer attributes: live bus values during SETUP, captured copies afterwards.
  assign addr_cur  = (state_eff == SETUP) ? PADDR  : addr_q;
  assign write_cur = (state_eff == SETUP) ? PWRITE : write_q;
  assign cur_bad   = aext_t'(addr_cur) >= aext_t'(DEPTH);
  assign q_bad     = aext_t'(addr_q)   >= aext_t'(DEPTH);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      wcnt_q  <= 3'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
      err_cnt <= 8'd0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (state_eff == SETUP) begin
        addr_q  <= PADDR;
        write_q <= PWRITE;
        wdata_q <= PWDATA;
      end
      PREADY  <= (state_d == READY);
      PSLVERR <= (state_d == READY) && cur_bad;
      // Read data is loaded on entry to READY and otherwise held.
      if (state_d == READY) begin
        if (cur_bad) begin
          PRDATA <= '0;
        end else if (!write_cur) begin
          PRDATA <= mem[addr_cur[IDX_W-1:0]];
        end
      end
      if (commit && write_q && !q_bad) begin
        mem[addr_q[IDX_W-1:0]] <= wdata_q;
      end
      if ((abort || (commit && q_bad)) && err_cnt != 8'hFF) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
`timescale 1ns/1ps
module tb_apb_slave_mem;

  logic        pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic        presetn;
  logic [2:0]  psel;
  logic        penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata  [3];
  logic        pready  [3];
  logic        pslverr [3];
  logic [7:0]  errc    [3];

  apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(64), .WAIT_CYCLES(0)) u_w0 (
    .PCLK(pclk), .PRESETn(presetn), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[0]), .PREADY(pready[0]),
    .PSLVERR(pslverr[0]), .err_cnt(errc[0]));
  apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(64), .WAIT_CYCLES(2)) u_w2 (
    .PCLK(pclk), .PRESETn(presetn), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[1]), .PREADY(pready[1]),
    .PSLVERR(pslverr[1]), .err_cnt(errc[1]));
  apb_slave_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(64), .WAIT_CYCLES(3)) u_w3 (
    .PCLK(pclk), .PRESETn(presetn), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[2]), .PREADY(pready[2]),
    .PSLVERR(pslverr[2]), .err_cnt(errc[2]));

  int          wc_of [3] = '{0, 2, 3};
  int          total = 0;
  int          bad   = 0;
  logic [31:0] mm   [3][64];
  int          merr [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      merr[k] = 0;
      for (int i = 0; i < 64; i++) mm[k][i] = 32'h0;
    end
  endtask

  // One APB transfer to instance k. Returns at #1 into the cycle where PREADY is
  // seen high, or when the wait budget runs out. Bus lines that must be ignored
  // after setup are scrambled while the slave is stalling.
  task automatic xfer(input int k, input bit wr, input logic [7:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er, output int waits);
    @(posedge pclk); #1;
    psel = '0; psel[k] = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge pclk); #1;
    penable = 1'b1;
    waits = 0;
    while (pready[k] !== 1'b1 && waits < 16) begin
      paddr = 8'($urandom); pwdata = $urandom; pwrite = 1'($urandom);
      @(posedge pclk); #1;
      waits++;
    end
    rd = prdata[k];
    er = pslverr[k];
  endtask

  task automatic idle();
    @(posedge pclk); #1;
    psel = '0; penable = 1'b0;
  endtask

  // Transfer checked against the reference model; the model is updated afterwards.
  task automatic do_op(input int k, input bit wr, input logic [7:0] a, input logic [31:0] d);
    logic [31:0] rd;
    logic        er;
    int          w;
    bit          oob;
    oob = (a >= 8'd64);
    xfer(k, wr, a, d, rd, er, w);
    chk("latency", w, wc_of[k]);
    chk("pslverr", {31'h0, er}, {31'h0, oob});
    if (oob) chk("rdata_err", rd, 32'h0);
    else if (!wr) chk("rdata", rd, mm[k][a]);
    if (oob) merr[k] = (merr[k] < 255) ? merr[k] + 1 : 255;
    else if (wr) mm[k][a] = d;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    presetn = 1'b0; psel = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    model_clear();
    repeat (3) @(posedge pclk);
    #1 presetn = 1'b1;

    // Reset state of every instance.
    for (int k = 0; k < 3; k++) begin
      chk("rst_pready",  {31'h0, pready[k]},  32'h0);
      chk("rst_pslverr", {31'h0, pslverr[k]}, 32'h0);
      chk("rst_prdata",  prdata[k],           32'h0);
      chk("rst_errcnt",  {24'h0, errc[k]},    32'h0);
    end

    // Zero-wait write then read back.
    do_op(0, 1'b1, 8'd5, 32'hDEADBEEF);
    do_op(0, 1'b0, 8'd5, 32'h0);
    chk("rd_deadbeef", mm[0][5], 32'hDEADBEEF);
    idle();

    // Out-of-range write and read, then a read of address 0.
    do_op(0, 1'b1, 8'd64, 32'h12345678);
    do_op(0, 1'b0, 8'd64, 32'h0);
    idle();
    chk("errcnt_oob", {24'h0, errc[0]}, 32'd2);
    do_op(0, 1'b0, 8'd0, 32'h0);
    idle();

    // Back-to-back writes with no idle cycle between them.
    do_op(0, 1'b1, 8'd1, 32'hA1A1A1A1);
    do_op(0, 1'b1, 8'd2, 32'hB2B2B2B2);
    do_op(0, 1'b0, 8'd1, 32'h0);
    do_op(0, 1'b0, 8'd2, 32'h0);
    idle();

    // PENABLE without a setup phase is ignored.
    @(posedge pclk); #1;
    psel[0] = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'd5; pwdata = 32'h0BADF00D;
    for (int i = 0; i < 3; i++) begin
      @(posedge pclk); #1;
      chk("no_setup_pready", {31'h0, pready[0]}, 32'h0);
    end
    idle();
    do_op(0, 1'b0, 8'd5, 32'h0);
    idle();

    // Three wait states, then PREADY high for exactly one cycle.
    do_op(2, 1'b0, 8'd10, 32'h0);
    idle();
    chk("w3_pready_drop", {31'h0, pready[2]}, 32'h0);

    // Abort during WAIT leaves the target word untouched.
    do_op(1, 1'b1, 8'd7, 32'hCAFE0007);
    idle();
    @(posedge pclk); #1;
    psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd7; pwdata = 32'h00000BAD;
    @(posedge pclk); #1;
    penable = 1'b1;
    chk("abort_wait_pready", {31'h0, pready[1]}, 32'h0);
    psel = '0; penable = 1'b0;
    @(posedge pclk); #1;
    merr[1] = merr[1] + 1;
    chk("abort_pready", {31'h0, pready[1]}, 32'h0);
    chk("abort_errcnt", {24'h0, errc[1]}, 32'd1);
    repeat (2) @(posedge pclk);
    #1 chk("abort_idle_pready", {31'h0, pready[1]}, 32'h0);
    do_op(1, 1'b0, 8'd7, 32'h0);
    idle();

    // Reset in the middle of a waited write.
    do_op(2, 1'b1, 8'd3, 32'h33333333);
    idle();
    @(posedge pclk); #1;
    psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd3; pwdata = 32'h44444444;
    @(posedge pclk); #1;
    penable = 1'b1;
    #2 presetn = 1'b0;
    #1 chk("rst_mid_pready", {31'h0, pready[2]}, 32'h0);
    chk("rst_mid_errcnt", {24'h0, errc[0]}, 32'h0);
    psel = '0; penable = 1'b0;
    @(posedge pclk); #1;
    presetn = 1'b1;
    model_clear();
    do_op(2, 1'b0, 8'd3, 32'h0);
    do_op(0, 1'b0, 8'd5, 32'h0);
    idle();

    // Randomised traffic across all instances.
    for (int n = 0; n < 150; n++) begin
      int          k;
      bit          wr;
      logic [7:0]  a;
      logic [31:0] d;
      k  = $urandom_range(0, 2);
      wr = 1'($urandom);
      a  = 8'($urandom_range(0, 71));
      d  = $urandom;
      do_op(k, wr, a, d);
      if ($urandom_range(0, 1) == 1) idle();
    end
    idle();
    for (int k = 0; k < 3; k++) chk("rand_errcnt", {24'h0, errc[k]}, merr[k]);

    // Error counter saturation.
    for (int n = 0; n < 260; n++) do_op(0, 1'b1, 8'(64 + (n % 8)), 32'h0);
    idle();
    chk("errcnt_sat", {24'h0, errc[0]}, 32'd255);
    chk("errcnt_sat_model", {24'h0, errc[0]}, merr[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
